// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC register, combinational ROM address, 2-entry {pc, instr} buffer to decode.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets a sticky misalign_err and halts fetch until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        misalign_err
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic [1:0] COUNT_FULL = 2'(BUF_DEPTH);

    state_e      state_q, state_d;
    logic        fetch_en;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        misalign_q, misalign_d;

    logic [31:0] buf_pc_q    [BUF_DEPTH];
    logic [31:0] buf_instr_q [BUF_DEPTH];

    logic        push;
    logic        pop;
    logic        redirect_misaligned;
    logic [31:0] redirect_target;

    assign redirect_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];
    assign redirect_misaligned = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (state_q == ST_RUN && redirect_misaligned) begin
            state_d = ST_HALT;
        end
    end

    // FSM: outputs
    always_comb begin
        fetch_en = (state_q == ST_RUN);
    end

    // A redirect masks the head combinationally so wrong-path words never reach decode.
    assign out_valid = (count_q != 2'd0) && !redirect_valid;
    assign pop       = out_valid && out_ready;
    assign push      = fetch_en && !redirect_valid && ((count_q != COUNT_FULL) || pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        misalign_d = misalign_q || redirect_misaligned;

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= fetch_pc_q;
            buf_instr_q[wr_ptr_q] <= instr_data;
        end
    end

    assign instr_addr   = fetch_pc_q;
    assign out_pc       = buf_pc_q[rd_ptr_q];
    assign out_instr    = buf_instr_q[rd_ptr_q];
    assign out_pc_plus4 = out_pc + 32'd4;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, back-pressure, redirect, wraparound, misaligned redirect, reset.
// Expectations follow FETCH_MISALIGN_CHECK_EN when it is defined for the build.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] instr_addr, instr_data, out_instr, out_pc, out_pc_plus4;
    logic        out_valid, misalign_err;

    logic [31:0] w_addr, w_data, w_instr, w_pc, w_pc_plus4;
    logic        w_valid, w_misalign;

    int checks = 0;
    int errors = 0;

    // ROM word k at byte address 4k is 0x100 + k.
    assign instr_data = 32'h100 + {2'b00, instr_addr[31:2]};
    assign w_data     = w_addr ^ 32'hA5A5_0000;

    fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr_addr     (instr_addr),
        .instr_data     (instr_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .misalign_err   (misalign_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .instr_addr     (w_addr),
        .instr_data     (w_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (w_valid),
        .out_ready      (1'b1),
        .out_instr      (w_instr),
        .out_pc         (w_pc),
        .out_pc_plus4   (w_pc_plus4),
        .misalign_err   (w_misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic head(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".instr"}, out_instr, instr);
        check({tag, ".pc4"}, out_pc_plus4, pc + 32'd4);
    endtask

    // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) tick();
        #1;
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.addr", instr_addr, 32'h0);
        check("rst.merr", {31'b0, misalign_err}, 32'd0);
        check("rst.waddr", w_addr, 32'hFFFF_FFF8);

        // Reset released: first head appears one cycle later.
        tick(); reset = 1'b0; out_ready = 1'b1; #1;
        check("c0.valid", {31'b0, out_valid}, 32'd0);
        check("c0.addr", instr_addr, 32'h0);
        tick(); #1;
        head("s0", 32'h0, 32'h100);
        check("w0.pc", w_pc, 32'hFFFF_FFF8);
        check("w0.instr", w_instr, 32'h5A5A_FFF8);
        tick(); #1;
        head("s1", 32'h4, 32'h101);
        check("w1.pc", w_pc, 32'hFFFF_FFFC);
        check("w1.pc4", w_pc_plus4, 32'h0);
        tick(); #1;
        head("s2", 32'h8, 32'h102);
        check("w2.pc", w_pc, 32'h0);
        check("w2.instr", w_instr, 32'hA5A5_0000);

        // Back-pressure for 5 cycles after pc 8 is accepted.
        for (int i = 0; i < 5; i++) begin
            tick(); out_ready = 1'b0; #1;
            head("bp", 32'hC, 32'h103);
        end
        check("bp.addr", instr_addr, 32'd20);
        tick(); out_ready = 1'b1; #1;
        head("rel0", 32'd12, 32'h103);
        tick(); #1;
        head("rel1", 32'd16, 32'h104);
        tick(); #1;
        head("rel2", 32'd20, 32'h105);

        // Redirect with full buffer and ready high: masked, no pop, target after one bubble.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'd136; #1;
        check("rd.n.valid", {31'b0, out_valid}, 32'd0);
        tick(); redirect_valid = 1'b0; #1;
        check("rd.n1.valid", {31'b0, out_valid}, 32'd0);
        check("rd.n1.addr", instr_addr, 32'd136);
        tick(); #1;
        head("rd.tgt", 32'd136, 32'h122);
        tick(); out_ready = 1'b0; #1;
        head("rd.next", 32'd140, 32'h123);
        tick(); #1;
        head("rd.hold", 32'd140, 32'h123);

        // Misaligned redirect to 141 with a full buffer.
        tick(); redirect_valid = 1'b1; redirect_pc = 32'd141; #1;
        check("ma.n.valid", {31'b0, out_valid}, 32'd0);
        tick(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        check("ma.n1.valid", {31'b0, out_valid}, 32'd0);
        check("ma.n1.addr", instr_addr, 32'd140);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("ma.halt.valid", {31'b0, out_valid}, 32'd0);
            check("ma.halt.merr", {31'b0, misalign_err}, 32'd1);
        end
`else
        tick(); #1;
        head("ma.tgt", 32'd140, 32'h123);
        check("ma.merr", {31'b0, misalign_err}, 32'd0);
        tick(); #1;
        head("ma.next", 32'd144, 32'h124);
`endif

        // Reset asserted together with a redirect: reset wins.
        tick(); reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd200; #1;
        tick(); redirect_valid = 1'b0; #1;
        check("rr.valid", {31'b0, out_valid}, 32'd0);
        check("rr.addr", instr_addr, 32'h0);
        check("rr.merr", {31'b0, misalign_err}, 32'd0);
        tick(); reset = 1'b0; #1;
        check("rr.c0.valid", {31'b0, out_valid}, 32'd0);
        tick(); #1;
        head("rr.s0", 32'h0, 32'h100);
        tick(); #1;
        head("rr.s1", 32'h4, 32'h101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Holds the program counter, drives the word address into the combinational instruction ROM, and captures each returned word with its PC into a 2-entry fetch buffer. The buffer feeds the decode stage through a valid/ready handshake. Taken branches and jumps from execute redirect it.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `BUF_DEPTH`, 2: fetch buffer entries. Fixed at 2; other values are unsupported.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `instr_addr` out 32: byte address to the ROM `addr` input. Equals the current fetch PC.
- `instr_data` in 32: ROM word, combinational from `instr_addr`.
- `redirect_valid` in 1: taken branch/JAL/JALR from execute.
- `redirect_pc` in 32: redirect target byte address.
- `out_valid` out 1: buffer head valid to decode.
- `out_ready` in 1: decode accepts the head.
- `out_instr` out 32: head instruction word.
- `out_pc` out 32: head instruction PC.
- `out_pc_plus4` out 32: `out_pc` + 4, used for JAL/JALR link value.
- `misalign_err` out 1: sticky misaligned-redirect flag. Tied 0 unless the macro is defined.

## Operation
- **State:** `fetch_pc` (32 b), 2-entry circular buffer of {pc, instr}, `rd_ptr`, `wr_ptr`, `count` (0..2), and FSM {RUN, HALT}.
- **Reset:** `fetch_pc`=`RESET_PC`, `count`=0, pointers 0, FSM=RUN, `misalign_err`=0. Outputs after reset:
  - `out_valid`=0
  - `out_instr`/`out_pc` = don't-care (bench must check only when valid)
  - `instr_addr`=`RESET_PC`
- **Pop:** `out_valid && out_ready && !redirect_valid`.
- **Push:** FSM==RUN, no redirect, and (`count`<2 or pop).
  - On push, {`fetch_pc`, `instr_data`} is written at `wr_ptr`.
  - `fetch_pc` advances by 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- **No push:** `fetch_pc` holds. `instr_addr` keeps presenting the same address.
- **Push and pop in the same cycle with `count`==2:** both happen; `count` stays 2.
- **`out_valid`** = (`count`!=0) && !`redirect_valid`. The redirect mask is combinational, so wrong-path heads are never handed over.
- **Redirect (highest priority):**
  - Buffer flushed: `count`=0, `rd_ptr`=`wr_ptr`=0.
  - `fetch_pc`=`{redirect_pc[31:2],2'b00}`.
  - No push and no pop that cycle.
- **Reset during redirect or stall:** reset wins; all state returns to reset values.
- **`out_pc_plus4`:** 32-bit wraparound add of `out_pc`.

## Timing
- **ROM:** combinational, so the instruction is captured in the same cycle its address is driven.
- **First fetch:** first `out_valid`=1 one cycle after the cycle `reset` is sampled low.
- **Sustained throughput:** 1 instruction/cycle with `out_ready` held high.
- **Redirect to target:** redirect in cycle N gives `out_valid`=0 in N and N+1. Target instruction is valid in N+1's successor (cycle N+2 from redirect assert, measured from the clock edge closing N). Effective penalty is 1 bubble cycle.
- **Back-pressure:** buffer fills in 2 cycles of `out_ready`=0. It then holds with PC frozen and no instruction lost or duplicated.

## Configuration
- **`FETCH_MISALIGN_CHECK_EN` defined:**
  - A redirect with `redirect_pc[1:0]`!=0 sets `misalign_err`=1 (sticky) and flushes the buffer.
  - FSM enters HALT: no further pushes, `out_valid` stays 0.
  - Only `reset` clears it.
- **Not defined:** low two bits of `redirect_pc` are silently cleared. `misalign_err` is constant 0 and HALT is unreachable.

## Test plan
- **Reset and stream:**
  - Stimulus: release reset with ROM word k = 32'h100+k and `out_ready`=1.
  - Required: outputs (pc, instr) = (0, 0x100), (4, 0x101), (8, 0x102) on consecutive cycles; `out_pc_plus4` = pc+4.
- **Back-pressure:**
  - Stimulus: drop `out_ready` for 5 cycles after pc 8 is accepted.
  - Required: head stays pc 12; `instr_addr` freezes at 20. On release, order continues 12, 16, 20 with no gaps or repeats.
- **Redirect:**
  - Stimulus: pulse `redirect_valid` with `redirect_pc`=136 while `count`=2.
  - Required: `out_valid`=0 that cycle and the next; then pc 136 with ROM[34]; prior buffered entries never appear.
- **Simultaneous redirect and ready with full buffer:**
  - Required: no pop counted; next valid head is the redirect target.
- **Wraparound:**
  - Stimulus: `RESET_PC`=32'hFFFF_FFF8.
  - Required: pcs FFFF_FFF8, FFFF_FFFC, 0000_0000; `out_pc_plus4` at FFFF_FFFC is 0.
- **Misaligned redirect:**
  - Stimulus: `redirect_pc`=141.
  - Required with macro: `misalign_err`=1 and `out_valid` stays 0 until reset.
  - Required without macro: next head pc is 140.
